// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU operand loader
package alu_pkg;

  localparam int ALU_N = 4;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } ld_state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - switch inputs and registered ALU-side outputs of the loader
interface alu_operand_loader_if import alu_pkg::*; #(
  parameter int N  = ALU_N,
  parameter int CW = 8
);

  logic [N-1:0]  sw_data;
  logic [2:0]    sw_op;
  logic          sw_sum;
  logic          sw_subt;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [2:0]    op;
  logic          op_sum;
  logic          op_subt;
  logic          operands_valid;
  logic          err;
  logic [1:0]    state_out;
  logic [CW-1:0] exec_count;

  modport master (
    output sw_data, sw_op, sw_sum, sw_subt,
    input  a, b, op, op_sum, op_subt, operands_valid, err, state_out, exec_count
  );

  modport slave (
    input  sw_data, sw_op, sw_sum, sw_subt,
    output a, b, op, op_sum, op_subt, operands_valid, err, state_out, exec_count
  );

endinterface

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - 2-FF synchronizer with one-clock rising-edge pulse
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] fill;

  // prev is held high until the synchronizer has refilled after reset, so a
  // button already held through reset does not produce a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b1;
      fill  <= 2'b00;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      prev  <= fill[1] ? sync2 : 1'b1;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - sequences A, B and op entry from switches into registered ALU inputs
module alu_operand_loader import alu_pkg::*; #(
  parameter int N  = ALU_N,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_clear,
  alu_operand_loader_if.slave  bus
);

  logic          next_pulse;
  logic          clear_pulse;
  ld_state_t     state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [2:0]    op_q;
  logic          op_sum_q;
  logic          op_subt_q;
  logic          err_q;
  logic [CW-1:0] exec_count_q;

  btn_edge_sync u_next_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .pulse (next_pulse)
  );

  btn_edge_sync u_clear_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .pulse (clear_pulse)
  );

  // Clear takes priority over next; a coincident next pulse is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_A;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      op_sum_q     <= 1'b0;
      op_subt_q    <= 1'b0;
      err_q        <= 1'b0;
      exec_count_q <= '0;
    end else if (clear_pulse) begin
      state     <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      op_sum_q  <= 1'b0;
      op_subt_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (next_pulse) begin
      case (state)
        S_A: begin
          a_q   <= bus.sw_data;
          state <= S_B;
        end
        S_B: begin
          b_q   <= bus.sw_data;
          state <= S_OP;
        end
        S_OP: begin
          if (bus.sw_sum && bus.sw_subt) begin
            err_q <= 1'b1;
          end else begin
            op_q         <= bus.sw_op;
            op_sum_q     <= bus.sw_sum;
            op_subt_q    <= bus.sw_subt;
            err_q        <= 1'b0;
            exec_count_q <= exec_count_q + CW'(1);
            state        <= S_RUN;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.op             = op_q;
  assign bus.op_sum         = op_sum_q;
  assign bus.op_subt        = op_subt_q;
  assign bus.err            = err_q;
  assign bus.state_out      = state;
  assign bus.operands_valid = (state == S_RUN);
  assign bus.exec_count     = exec_count_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench for alu_operand_loader
module tb_alu_operand_loader;

  localparam int N  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       s;
    logic       t;
    logic       err;
    logic [1:0] st;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_next = 1'b0;
  logic btn_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  exp_t m;
  exp_t exp_q[$];

  alu_operand_loader_if #(.N(N), .CW(CW)) bus ();

  alu_operand_loader #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check_eq({tag, ".a"}, 32'(bus.a), 32'(e.a));
    check_eq({tag, ".b"}, 32'(bus.b), 32'(e.b));
    check_eq({tag, ".op"}, 32'(bus.op), 32'(e.op));
    check_eq({tag, ".op_sum"}, 32'(bus.op_sum), 32'(e.s));
    check_eq({tag, ".op_subt"}, 32'(bus.op_subt), 32'(e.t));
    check_eq({tag, ".err"}, 32'(bus.err), 32'(e.err));
    check_eq({tag, ".state"}, 32'(bus.state_out), 32'(e.st));
    check_eq({tag, ".valid"}, 32'(bus.operands_valid), 32'(e.st == 2'b11));
    check_eq({tag, ".count"}, 32'(bus.exec_count), 32'(e.cnt));
  endtask

  task automatic model_step(input logic n, input logic c);
    if (c) begin
      m.st = 2'b00; m.a = '0; m.b = '0; m.op = '0; m.s = 1'b0; m.t = 1'b0; m.err = 1'b0;
    end else if (n) begin
      case (m.st)
        2'b00: begin m.a = bus.sw_data; m.st = 2'b01; end
        2'b01: begin m.b = bus.sw_data; m.st = 2'b10; end
        2'b10: begin
          if (bus.sw_sum && bus.sw_subt) m.err = 1'b1;
          else begin
            m.op = bus.sw_op; m.s = bus.sw_sum; m.t = bus.sw_subt; m.err = 1'b0;
            m.cnt = m.cnt + 2'd1; m.st = 2'b11;
          end
        end
        default: m.st = 2'b00;
      endcase
    end
  endtask

  task automatic set_sw(input logic [3:0] d, input logic [2:0] o, input logic s, input logic t);
    @(negedge clk);
    bus.sw_data = d; bus.sw_op = o; bus.sw_sum = s; bus.sw_subt = t;
  endtask

  // Buttons rise before edge k; outputs must be old at k+1 and new at k+2.
  task automatic press(input string tag, input logic n, input logic c, input int hold);
    exp_t pre;
    exp_t e;
    pre = m;
    model_step(n, c);
    exp_q.push_back(m);
    @(negedge clk);
    btn_next = n; btn_clear = c;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compare_all({tag, "@k+1"}, pre);
    @(posedge clk); #1;
    check_eq({tag, ".sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare_all(tag, e);
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      compare_all({tag, ".held"}, m);
    end
    @(negedge clk);
    btn_next = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.sw_data = 4'($urandom); bus.sw_op = 3'($urandom);
      bus.sw_sum = 1'($urandom); bus.sw_subt = 1'($urandom);
    end
    @(posedge clk); #1;
    compare_all(tag, m);
  endtask

  task automatic full_load(input string tag, input logic [3:0] av, input logic [3:0] bv, input logic [2:0] ov);
    set_sw(av, 3'b000, 1'b0, 1'b0);
    press({tag, ".A"}, 1'b1, 1'b0, 0);
    set_sw(bv, 3'b000, 1'b0, 1'b0);
    press({tag, ".B"}, 1'b1, 1'b0, 0);
    set_sw(4'h0, ov, 1'b0, 1'b1);
    press({tag, ".OP"}, 1'b1, 1'b0, 0);
  endtask

  initial begin
    m = '0;
    bus.sw_data = '0; bus.sw_op = '0; bus.sw_sum = 1'b0; bus.sw_subt = 1'b0;

    // Reset with both buttons held; no pulse may follow the release of rst.
    btn_next = 1'b1; btn_clear = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset", m);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    compare_all("reset_held_btns", m);
    @(negedge clk);
    btn_next = 1'b0; btn_clear = 1'b0;
    repeat (4) @(negedge clk);

    set_sw(4'h9, 3'b000, 1'b0, 1'b0);
    press("load_a", 1'b1, 1'b0, 0);
    set_sw(4'h3, 3'b000, 1'b0, 1'b0);
    press("load_b", 1'b1, 1'b0, 0);
    set_sw(4'h0, 3'b110, 1'b1, 1'b0);
    press("load_op", 1'b1, 1'b0, 0);
    idle("run_idle", 5);
    press("run_to_a", 1'b1, 1'b0, 0);

    set_sw(4'h5, 3'b000, 1'b0, 1'b0);
    press("load_a2", 1'b1, 1'b0, 0);
    set_sw(4'h6, 3'b000, 1'b0, 1'b0);
    press("load_b2", 1'b1, 1'b0, 0);
    set_sw(4'h0, 3'b101, 1'b1, 1'b1);
    press("bad_op", 1'b1, 1'b0, 0);
    set_sw(4'h0, 3'b011, 1'b1, 1'b0);
    press("good_op", 1'b1, 1'b0, 0);
    press("run_to_a2", 1'b1, 1'b0, 0);

    set_sw(4'hA, 3'b000, 1'b0, 1'b0);
    press("hold_next", 1'b1, 1'b0, 18);
    idle("after_hold", 6);

    set_sw(4'h7, 3'b000, 1'b0, 1'b0);
    press("load_b3", 1'b1, 1'b0, 0);
    set_sw(4'h0, 3'b001, 1'b1, 1'b0);
    press("clear_and_next", 1'b1, 1'b1, 0);

    full_load("wrap3", 4'hC, 4'h1, 3'b010);
    press("wrap3_run_to_a", 1'b1, 1'b0, 0);
    full_load("wrap0", 4'hF, 4'hE, 3'b111);
    press("wrap0_run_to_a", 1'b1, 1'b0, 0);
    press("clear_in_a", 1'b0, 1'b1, 0);
    idle("final_idle", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
